// File: rtl/bram_capture_ctrl_pkg.sv
// Shared types and default sizing for the sample-logging capture controller.
// The sizing defaults describe the logging RAM that sits beside the controller.
package bram_capture_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_ADDR_WIDTH   = 15;
    localparam int DEFAULT_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/bram_capture_ctrl_if.sv
// Bundle of sample, host-read and RAM-side signals of the capture controller.
// The controller uses the slave modport; the driving environment uses master.
interface bram_capture_ctrl_if
    import bram_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

    logic                  i_start;
    logic                  i_stop;
    logic                  i_sample_valid;
    logic [DATA_WIDTH-1:0] i_sample;
    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  o_ram_wr_en;
    logic [ADDR_WIDTH-1:0] o_ram_wr_addr;
    logic [DATA_WIDTH-1:0] o_ram_wr_data;
    logic                  o_ram_rd_en;
    logic [ADDR_WIDTH-1:0] o_ram_rd_addr;
    logic [DATA_WIDTH-1:0] i_ram_rd_data;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_busy;
    logic                  o_full;
    logic [ADDR_WIDTH:0]   o_wr_count;

    modport slave (
        input  i_start, i_stop, i_sample_valid, i_sample, i_rd_req, i_rd_addr,
        input  i_ram_rd_data,
        output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_rd_en, o_ram_rd_addr,
        output o_rd_data, o_rd_valid, o_busy, o_full, o_wr_count
    );

    modport master (
        output i_start, i_stop, i_sample_valid, i_sample, i_rd_req, i_rd_addr,
        output i_ram_rd_data,
        input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_rd_en, o_ram_rd_addr,
        input  o_rd_data, o_rd_valid, o_busy, o_full, o_wr_count
    );

endinterface

// File: rtl/bram_capture_ctrl_valid_delay_line.sv
// Single-bit shift register that delays the RAM read strobe by the RAM's
// read latency so the host sees a valid flag aligned with the RAM data.
module bram_capture_ctrl_valid_delay_line #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_out
);

    logic [STAGES-1:0] sr_q;
    logic [STAGES-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = i_in;
        for (int i = 1; i < STAGES; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_out = sr_q[STAGES-1];

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture/readout controller in front of the sample-logging block RAM: streams
// samples into the RAM after a start pulse, then serves latency-aligned reads.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset; host reads allowed, waiting for i_start
// ST_CAPTURE | writing valid samples at consecutive addresses; reads dropped
// ST_DONE    | capture ended (full or stopped); host reads allowed, restartable
module bram_capture_ctrl
    import bram_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                 clk,
    input  logic                 i_reset,
    bram_capture_ctrl_if.slave   bus
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    cap_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_en;

    // The word count doubles as the write pointer; it never wraps because the
    // write of the last address moves the FSM out of capture.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        full_d    = full_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    state_d = ST_CAPTURE;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (bus.i_sample_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_WIDTH-1:0];
                    wr_data_d = bus.i_sample;
                    count_d   = count_q + 1'b1;
                    if (count_q == LAST_ADDR) begin
                        full_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                if (bus.i_stop) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            full_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            full_q    <= full_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Requests arriving during capture are discarded rather than queued.
    assign rd_en = bus.i_rd_req && (state_q != ST_CAPTURE) && !i_reset;

    bram_capture_ctrl_valid_delay_line #(
        .STAGES (READ_LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .i_reset (i_reset),
        .i_in    (rd_en),
        .o_out   (bus.o_rd_valid)
    );

    assign bus.o_ram_wr_en   = wr_en_q;
    assign bus.o_ram_wr_addr = wr_addr_q;
    assign bus.o_ram_wr_data = wr_data_q;
    assign bus.o_ram_rd_en   = rd_en;
    assign bus.o_ram_rd_addr = bus.i_rd_addr;
    assign bus.o_rd_data     = bus.i_ram_rd_data;
    assign bus.o_busy        = (state_q == ST_CAPTURE);
    assign bus.o_full        = full_q;
    assign bus.o_wr_count    = count_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Directed bench: a default build (32x32768, latency 2) and a small build
// (16 words, latency 1), each paired with a behavioural RAM model.
module tb_bram_capture_ctrl;
    import bram_capture_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

    bram_capture_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) bus_a ();
    bram_capture_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  bus_b ();

    bram_capture_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .READ_LATENCY(2)) dut_a (
        .clk     (clk),
        .i_reset (rst_a),
        .bus     (bus_a)
    );

    bram_capture_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1)) dut_b (
        .clk     (clk),
        .i_reset (rst_b),
        .bus     (bus_b)
    );

    // Output-registered RAM (2 cycles) for A, low-latency RAM (1 cycle) for B
    logic [31:0] mem_a [32768];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_a1, pipe_a2, pipe_b1;

    always @(posedge clk) begin
        if (bus_a.o_ram_wr_en) mem_a[bus_a.o_ram_wr_addr] <= bus_a.o_ram_wr_data;
        if (bus_a.o_ram_rd_en) pipe_a1 <= mem_a[bus_a.o_ram_rd_addr];
        pipe_a2 <= pipe_a1;
        if (bus_b.o_ram_wr_en) mem_b[bus_b.o_ram_wr_addr] <= bus_b.o_ram_wr_data;
        if (bus_b.o_ram_rd_en) pipe_b1 <= mem_b[bus_b.o_ram_rd_addr];
    end

    assign bus_a.i_ram_rd_data = pipe_a2;
    assign bus_b.i_ram_rd_data = pipe_b1;

    typedef struct {
        logic        start;
        logic        stop;
        logic        sv;
        logic [31:0] sample;
        logic        rd_req;
        logic [14:0] rd_addr;
        logic        e_wr_en;
        logic [14:0] e_addr;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_full;
        logic [15:0] e_count;
        logic        e_valid;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, input logic sp, input logic sv,
                                input logic [31:0] smp, input logic rq, input logic [14:0] ra,
                                input logic we, input logic [14:0] wa, input logic [31:0] wd,
                                input logic bz, input logic fl, input logic [15:0] cnt,
                                input logic vl, input logic [31:0] rd);
        vec_t v;
        v.start = st;   v.stop = sp;    v.sv = sv;       v.sample = smp;
        v.rd_req = rq;  v.rd_addr = ra; v.e_wr_en = we;  v.e_addr = wa;
        v.e_data = wd;  v.e_busy = bz;  v.e_full = fl;   v.e_count = cnt;
        v.e_valid = vl; v.e_rdata = rd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic st, input logic sp, input logic sv,
                           input logic [31:0] smp, input logic rq, input logic [14:0] ra);
        bus_a.i_start        = st;
        bus_a.i_stop         = sp;
        bus_a.i_sample_valid = sv;
        bus_a.i_sample       = smp;
        bus_a.i_rd_req       = rq;
        bus_a.i_rd_addr      = ra;
    endtask

    task automatic drive_b(input logic st, input logic sv, input logic [31:0] smp,
                           input logic rq, input logic [3:0] ra);
        bus_b.i_start        = st;
        bus_b.i_stop         = 1'b0;
        bus_b.i_sample_valid = sv;
        bus_b.i_sample       = smp;
        bus_b.i_rd_req       = rq;
        bus_b.i_rd_addr      = ra;
    endtask

    initial begin
        int nwr;

        vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0,
                     1'b0, 15'd0, 32'h0, 1'b1, 1'b0, 16'd0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            vecs[1+i] = mk(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0, 15'd0,
                           1'b1, 15'(i), 32'hA0 + 32'(i), 1'b1, 1'b0, 16'(i + 1), 1'b0, 32'h0);
        end
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 15'd0,
                      1'b0, 15'd0, 32'h0, 1'b0, 1'b0, 16'd8, 1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 15'd3,
                      1'b0, 15'd0, 32'h0, 1'b0, 1'b0, 16'd8, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0,
                      1'b0, 15'd0, 32'h0, 1'b0, 1'b0, 16'd8, 1'b1, 32'hA3);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0,
                      1'b0, 15'd0, 32'h0, 1'b0, 1'b0, 16'd8, 1'b0, 32'h0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        chk("reset wr_en",   64'(bus_a.o_ram_wr_en),   64'(0));
        chk("reset wr_addr", 64'(bus_a.o_ram_wr_addr), 64'(0));
        chk("reset wr_data", 64'(bus_a.o_ram_wr_data), 64'(0));
        chk("reset rd_en",   64'(bus_a.o_ram_rd_en),   64'(0));
        chk("reset rd_valid",64'(bus_a.o_rd_valid),    64'(0));
        chk("reset busy",    64'(bus_a.o_busy),        64'(0));
        chk("reset full",    64'(bus_a.o_full),        64'(0));
        chk("reset count",   64'(bus_a.o_wr_count),    64'(0));

        // 8-sample capture, stop, then read address 3
        for (int i = 0; i < NV; i++) begin
            drive_a(vecs[i].start, vecs[i].stop, vecs[i].sv, vecs[i].sample,
                    vecs[i].rd_req, vecs[i].rd_addr);
            step();
            chk($sformatf("vec%0d wr_en", i), 64'(bus_a.o_ram_wr_en), 64'(vecs[i].e_wr_en));
            if (vecs[i].e_wr_en) begin
                chk($sformatf("vec%0d wr_addr", i), 64'(bus_a.o_ram_wr_addr), 64'(vecs[i].e_addr));
                chk($sformatf("vec%0d wr_data", i), 64'(bus_a.o_ram_wr_data), 64'(vecs[i].e_data));
            end
            chk($sformatf("vec%0d busy", i),     64'(bus_a.o_busy),     64'(vecs[i].e_busy));
            chk($sformatf("vec%0d full", i),     64'(bus_a.o_full),     64'(vecs[i].e_full));
            chk($sformatf("vec%0d count", i),    64'(bus_a.o_wr_count), 64'(vecs[i].e_count));
            chk($sformatf("vec%0d rd_valid", i), 64'(bus_a.o_rd_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d rd_data", i), 64'(bus_a.o_rd_data), 64'(vecs[i].e_rdata));
            end
        end

        // Restart from DONE, gapped valids, start ignored mid-capture, stop with 5th valid
        drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        chk("restart busy",  64'(bus_a.o_busy),     64'(1));
        chk("restart count", 64'(bus_a.o_wr_count), 64'(0));
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b0, k == 4, 1'b1, 32'hB0 + 32'(k), 1'b0, 15'd0);
            step();
            chk($sformatf("gap%0d wr_en", k),   64'(bus_a.o_ram_wr_en),   64'(1));
            chk($sformatf("gap%0d wr_addr", k), 64'(bus_a.o_ram_wr_addr), 64'(k));
            chk($sformatf("gap%0d wr_data", k), 64'(bus_a.o_ram_wr_data), 64'(32'hB0 + 32'(k)));
            if (k < 4) begin
                drive_a(k == 1, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
                step();
                drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
                step();
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        chk("gap count", 64'(bus_a.o_wr_count), 64'(5));
        chk("gap busy",  64'(bus_a.o_busy),     64'(0));
        chk("gap full",  64'(bus_a.o_full),     64'(0));
        chk("gap state", 64'(dut_a.state_q),    64'(ST_DONE));
        step();
        chk("gap wr_en after stop", 64'(bus_a.o_ram_wr_en), 64'(0));

        // Reads issued during capture are dropped
        drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(k), 1'b1, 15'(k));
            #1;
            chk($sformatf("cap rd_en%0d", k), 64'(bus_a.o_ram_rd_en), 64'(0));
            step();
            chk($sformatf("cap rd_valid%0d", k), 64'(bus_a.o_rd_valid), 64'(0));
        end
        drive_a(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        chk("cap stop rd_valid", 64'(bus_a.o_rd_valid), 64'(0));
        chk("cap stop busy",     64'(bus_a.o_busy),     64'(0));
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        chk("cap idle rd_valid", 64'(bus_a.o_rd_valid), 64'(0));

        // Back-to-back reads of addresses 0..4 in DONE
        for (int k = 0; k < 7; k++) begin
            drive_a(1'b0, 1'b0, 1'b0, 32'h0, k < 5, 15'(k));
            if (k < 5) begin
                #1;
                chk($sformatf("b2b rd_en%0d", k),   64'(bus_a.o_ram_rd_en),   64'(1));
                chk($sformatf("b2b rd_addr%0d", k), 64'(bus_a.o_ram_rd_addr), 64'(k));
            end
            step();
            chk($sformatf("b2b rd_valid%0d", k), 64'(bus_a.o_rd_valid), 64'(k >= 1 && k <= 5));
            if (k >= 1 && k <= 5) begin
                chk($sformatf("b2b rd_data%0d", k), 64'(bus_a.o_rd_data), 64'(32'hC0 + 32'(k - 1)));
            end
        end

        // Reset discards an in-flight read valid
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 15'd2);
        step();
        rst_a = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        rst_a = 1'b0;
        chk("rst inflight rd_valid", 64'(bus_a.o_rd_valid), 64'(0));
        chk("rst inflight count",    64'(bus_a.o_wr_count), 64'(0));

        // Reset in the middle of a capture, at word 6
        drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            drive_a(1'b0, 1'b0, 1'b1, 32'hD0 + 32'(k), 1'b0, 15'd0);
            step();
        end
        chk("pre-reset count", 64'(bus_a.o_wr_count), 64'(6));
        rst_a = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1, 32'hD6, 1'b0, 15'd0);
        step();
        rst_a = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        chk("midrst busy",     64'(bus_a.o_busy),      64'(0));
        chk("midrst count",    64'(bus_a.o_wr_count),  64'(0));
        chk("midrst rd_valid", 64'(bus_a.o_rd_valid),  64'(0));
        chk("midrst wr_en",    64'(bus_a.o_ram_wr_en), 64'(0));
        chk("midrst full",     64'(bus_a.o_full),      64'(0));
        step();
        drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        step();
        drive_a(1'b0, 1'b0, 1'b1, 32'hE0, 1'b0, 15'd0);
        step();
        drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 15'd0);
        chk("resume wr_en",   64'(bus_a.o_ram_wr_en),   64'(1));
        chk("resume wr_addr", 64'(bus_a.o_ram_wr_addr), 64'(0));
        chk("resume wr_data", 64'(bus_a.o_ram_wr_data), 64'(32'hE0));
        chk("resume count",   64'(bus_a.o_wr_count),    64'(1));

        // Small build: fill 16 words with 20 samples, latency-1 read back
        drive_b(1'b1, 1'b0, 32'h0, 1'b0, 4'd0);
        step();
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            drive_b(1'b0, 1'b1, 32'hF00 + 32'(i), 1'b0, 4'd0);
            step();
            if (bus_b.o_ram_wr_en) nwr++;
            if (i == 14) begin
                chk("fill15 full",  64'(bus_b.o_full),     64'(0));
                chk("fill15 busy",  64'(bus_b.o_busy),     64'(1));
                chk("fill15 count", 64'(bus_b.o_wr_count), 64'(15));
            end
            if (i == 15) begin
                chk("fill16 wr_en",   64'(bus_b.o_ram_wr_en),   64'(1));
                chk("fill16 wr_addr", 64'(bus_b.o_ram_wr_addr), 64'(15));
                chk("fill16 full",    64'(bus_b.o_full),        64'(1));
                chk("fill16 busy",    64'(bus_b.o_busy),        64'(0));
            end
        end
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
        step();
        if (bus_b.o_ram_wr_en) nwr++;
        chk("fill writes", 64'(nwr),               64'(16));
        chk("fill full",   64'(bus_b.o_full),      64'(1));
        chk("fill busy",   64'(bus_b.o_busy),      64'(0));
        chk("fill count",  64'(bus_b.o_wr_count),  64'(16));
        drive_b(1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
        #1;
        chk("lat1 rd_en", 64'(bus_b.o_ram_rd_en), 64'(1));
        step();
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
        chk("lat1 rd_valid", 64'(bus_b.o_rd_valid), 64'(1));
        chk("lat1 rd_data",  64'(bus_b.o_rd_data),  64'(32'hF00));
        step();
        chk("lat1 rd_valid drop", 64'(bus_b.o_rd_valid), 64'(0));
        drive_b(1'b1, 1'b0, 32'h0, 1'b0, 4'd0);
        step();
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
        chk("refill full",  64'(bus_b.o_full),     64'(0));
        chk("refill count", 64'(bus_b.o_wr_count), 64'(0));
        chk("refill busy",  64'(bus_b.o_busy),     64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
